// File: rtl/song_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : song_seq_pkg
// Purpose : Shared definitions for the polyphonic song sequencer: FSM state
//           encoding, rest note code and helpers that derive the packed
//           song-entry field positions from the field widths.
//           Entry layout (MSB..LSB): {advance, note, duration, meta}
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package song_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_DISPATCH = 3'd3,
      ST_WAIT     = 3'd4,
      ST_INCR     = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   // Note code that marks a rest (no voice is allocated).
   localparam int REST_NOTE = 0;

   // Meta occupies the least-significant bits of an entry.
   localparam int META_LSB = 0;

   function automatic int entry_width(input int note_w, input int dur_w, input int meta_w);
      return 1 + note_w + dur_w + meta_w;
   endfunction

   function automatic int dur_lsb(input int meta_w);
      return meta_w;
   endfunction

   function automatic int note_lsb(input int dur_w, input int meta_w);
      return meta_w + dur_w;
   endfunction

   function automatic int adv_bit(input int note_w, input int dur_w, input int meta_w);
      return note_w + dur_w + meta_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module  : voice_alloc
// Purpose : Note-player allocation. Tracks which voices are busy, grants the
//           lowest-index free voice on request, clears busy on voice_done.
//           A voice finishing in the same cycle it is granted stays busy.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           i_req          - dispatch request (grant issued only if a voice is free)
//           i_done         - per-voice one-cycle "note finished"
//           o_busy         - registered busy vector
//           o_grant        - one-hot grant (zero when no request / no free voice)
//           o_any_free     - at least one voice is free this cycle
// Revision: 1.0 - initial release
// ============================================================================
module voice_alloc
   import song_seq_pkg::*;
#(
   parameter int VOICES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [VOICES-1:0] i_done,
   output logic [VOICES-1:0] o_busy,
   output logic [VOICES-1:0] o_grant,
   output logic              o_any_free
);

   logic [VOICES-1:0] r_busy;
   logic [VOICES-1:0] w_free;
   logic [VOICES-1:0] w_lowest;

   // A voice finishing this cycle can be reused immediately.
   assign w_free     = ~r_busy | i_done;
   // Two's-complement trick isolates the lowest set bit of the free vector.
   assign w_lowest   = w_free & (~w_free + VOICES'(1));
   assign o_any_free = |w_free;
   assign o_grant    = i_req ? w_lowest : '0;
   assign o_busy     = r_busy;

   // Done on an idle voice is a no-op; a grant overrides a same-cycle done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~i_done) | o_grant;
      end
   end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : song_sequencer
// Purpose : Walks a song ROM, decodes packed entries {advance, note, duration,
//           meta} and dispatches each note to the lowest free voice of a
//           note-player bank. Supports chords (advance=0), rests (note=0) and
//           beat-counted waits between time steps.
//           Build option SONG_SEQ_LOOP_EN: song loops forever instead of
//           stopping in DONE at end of song (song_done still pulses).
// Ports   : clk, reset    - clock, asynchronous active-low reset
//           play          - 1 = run, 0 = freeze (IDLE/DONE use it as start/rearm)
//           song          - song select, sampled only when leaving IDLE
//           beat          - one-cycle beat strobe
//           voice_done    - per-voice "note finished" strobe
//           rom_addr      - {song_q, ptr}; rom_data valid one cycle later
//           rom_data      - packed song entry
//           new_note      - one-hot dispatch strobe
//           note/duration/meta - registered fields of the last decoded entry
//           voice_busy    - voice allocation state
//           song_done     - one-cycle end-of-song pulse
// Revision: 1.0 - initial release
// ============================================================================
module song_sequencer
   import song_seq_pkg::*;
#(
   parameter int SONG_BITS = 2,
   parameter int ADDR_BITS = 5,
   parameter int NOTE_W    = 6,
   parameter int DUR_W     = 6,
   parameter int META_W    = 3,
   parameter int VOICES    = 3
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             play,
   input  logic [SONG_BITS-1:0]                             song,
   input  logic                                             beat,
   input  logic [VOICES-1:0]                                voice_done,
   output logic [SONG_BITS+ADDR_BITS-1:0]                   rom_addr,
   input  logic [entry_width(NOTE_W, DUR_W, META_W)-1:0]    rom_data,
   output logic [VOICES-1:0]                                new_note,
   output logic [NOTE_W-1:0]                                note,
   output logic [DUR_W-1:0]                                 duration,
   output logic [META_W-1:0]                                meta,
   output logic [VOICES-1:0]                                voice_busy,
   output logic                                             song_done
);

   localparam int ADV_BIT  = adv_bit(NOTE_W, DUR_W, META_W);
   localparam int NOTE_LSB = note_lsb(DUR_W, META_W);
   localparam int DUR_LSB  = dur_lsb(META_W);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t                 r_state;
   logic [SONG_BITS-1:0]   r_song_q;
   logic [ADDR_BITS-1:0]   r_ptr;
   logic [DUR_W-1:0]       r_count;
   logic                   r_adv;
   logic [NOTE_W-1:0]      r_note;
   logic [DUR_W-1:0]       r_dur;
   logic [META_W-1:0]      r_meta;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   state_t                 w_next;
   logic                   w_load_song;
   logic                   w_latch_entry;
   logic                   w_load_count;
   logic                   w_dec_count;
   logic                   w_incr_ptr;
   logic                   w_done_pulse;
   logic                   w_req;
   logic                   w_any_free;
   logic [VOICES-1:0]      w_grant;
   logic [VOICES-1:0]      w_busy;
   logic [DUR_W-1:0]       w_count_src;

   // Entry fields straight from the ROM (valid during DECODE).
   logic                   w_rom_adv;
   logic [NOTE_W-1:0]      w_rom_note;
   logic [DUR_W-1:0]       w_rom_dur;
   logic [META_W-1:0]      w_rom_meta;

   assign w_rom_adv  = rom_data[ADV_BIT];
   assign w_rom_note = rom_data[NOTE_LSB +: NOTE_W];
   assign w_rom_dur  = rom_data[DUR_LSB  +: DUR_W];
   assign w_rom_meta = rom_data[META_LSB +: META_W];

   // Rests load the wait count directly from the ROM in DECODE; notes load it
   // from the latched entry once they have been granted in DISPATCH.
   assign w_count_src = (r_state == ST_DECODE) ? w_rom_dur : r_dur;

   // ------------------------------------------------------------------
   // Voice allocation
   // ------------------------------------------------------------------
   voice_alloc #(
      .VOICES (VOICES)
   ) u_voice_alloc (
      .clk        (clk),
      .rst_n      (reset),
      .i_req      (w_req),
      .i_done     (voice_done),
      .o_busy     (w_busy),
      .o_grant    (w_grant),
      .o_any_free (w_any_free)
   );

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state / control. play=0 freezes every running state.
   // ------------------------------------------------------------------
   always_comb begin
      w_next        = r_state;
      w_load_song   = 1'b0;
      w_latch_entry = 1'b0;
      w_load_count  = 1'b0;
      w_dec_count   = 1'b0;
      w_incr_ptr    = 1'b0;
      w_done_pulse  = 1'b0;
      w_req         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (play) begin
               w_load_song = 1'b1;
               w_next      = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (play) begin
               w_next = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (play) begin
               w_latch_entry = 1'b1;
               if (w_rom_note != NOTE_W'(REST_NOTE)) begin
                  w_next = ST_DISPATCH;
               end else if (w_rom_adv && (w_rom_dur != '0)) begin
                  w_load_count = 1'b1;
                  w_next       = ST_WAIT;
               end else begin
                  w_next = ST_INCR;
               end
            end
         end

         ST_DISPATCH: begin
            if (play) begin
               w_req = 1'b1;
               // With no free voice the request simply repeats next cycle.
               if (w_any_free) begin
                  if (r_adv && (r_dur != '0)) begin
                     w_load_count = 1'b1;
                     w_next       = ST_WAIT;
                  end else begin
                     w_next = ST_INCR;
                  end
               end
            end
         end

         ST_WAIT: begin
            if (play && beat) begin
               if (r_count == DUR_W'(1)) begin
                  w_next = ST_INCR;
               end else begin
                  w_dec_count = 1'b1;
               end
            end
         end

         ST_INCR: begin
            if (play) begin
               w_incr_ptr = 1'b1;
               if (&r_ptr) begin
                  w_done_pulse = 1'b1;
`ifdef SONG_SEQ_LOOP_EN
                  w_next = ST_FETCH;
`else
                  w_next = ST_DONE;
`endif
               end else begin
                  w_next = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            // Requires play to drop before a new song can start.
            if (!play) begin
               w_next = ST_IDLE;
            end
         end

         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_song_q <= '0;
         r_ptr    <= '0;
         r_count  <= '0;
         r_adv    <= 1'b0;
         r_note   <= '0;
         r_dur    <= '0;
         r_meta   <= '0;
      end else begin
         if (w_load_song) begin
            r_song_q <= song;
            r_ptr    <= '0;
         end else if (w_incr_ptr) begin
            // Wraps to zero after the last entry.
            r_ptr <= r_ptr + ADDR_BITS'(1);
         end

         if (w_latch_entry) begin
            r_adv  <= w_rom_adv;
            r_note <= w_rom_note;
            r_dur  <= w_rom_dur;
            r_meta <= w_rom_meta;
         end

         if (w_load_count) begin
            r_count <= w_count_src;
         end else if (w_dec_count) begin
            r_count <= r_count - DUR_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rom_addr   = {r_song_q, r_ptr};
   assign new_note   = w_grant;
   assign note       = r_note;
   assign duration   = r_dur;
   assign meta       = r_meta;
   assign voice_busy = w_busy;
   assign song_done  = w_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_song_sequencer
// Purpose : Self-checking bench for song_sequencer: directed timing steps on
//           songs 1 and 2, then a randomized song 3 checked against an
//           ordered dispatch list and a lowest-free-voice allocation model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

   localparam int SB = 2;
   localparam int AB = 5;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int MW = 3;
   localparam int V  = 3;
   localparam int EW = 1 + NW + DW + MW;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           play = 1'b0;
   logic [SB-1:0]  song = '0;
   logic           beat = 1'b0;
   logic [V-1:0]   voice_done = '0;
   logic [SB+AB-1:0] rom_addr;
   logic [EW-1:0]  rom_data;
   logic [V-1:0]   new_note;
   logic [NW-1:0]  note;
   logic [DW-1:0]  duration;
   logic [MW-1:0]  meta;
   logic [V-1:0]   voice_busy;
   logic           song_done;

   int n_tests = 0;
   int n_fail  = 0;

   song_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .play       (play),
      .song       (song),
      .beat       (beat),
      .voice_done (voice_done),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .new_note   (new_note),
      .note       (note),
      .duration   (duration),
      .meta       (meta),
      .voice_busy (voice_busy),
      .song_done  (song_done)
   );

   always #5 clk = ~clk;

   // Synchronous song ROM: data one cycle after address.
   logic [EW-1:0] rom_mem [0:(1<<(SB+AB))-1];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   function automatic logic [EW-1:0] ent(input logic adv, input int n, input int d, input int m);
      logic [NW-1:0] nn;
      logic [DW-1:0] dd;
      logic [MW-1:0] mm;
      nn = NW'(n);
      dd = DW'(d);
      mm = MW'(m);
      return {adv, nn, dd, mm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; strobes drop automatically, then settle.
   task automatic tick();
      @(posedge clk);
      #1;
      beat       = 1'b0;
      voice_done = '0;
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_addr(input logic [SB+AB-1:0] a, input int max, input string tag);
      int k;
      k = 0;
      while (rom_addr !== a && k < max) begin
         tick();
         k++;
      end
      chk(tag, rom_addr, a);
   endtask

   // ------------------------------------------------------------------
   // Reference model for the randomized song: expected dispatches in ROM
   // order, and voice occupancy as a set of busy voices.
   // ------------------------------------------------------------------
   typedef struct {
      logic [NW-1:0] n;
      logic [DW-1:0] d;
      logic [MW-1:0] m;
   } exp_t;

   exp_t       exp_q[$];
   bit         mbusy [V];
   bit         mon_en = 1'b0;
   bit         done_seen = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         int   idx;
         exp_t e;
         logic [V-1:0] exp_g;
         logic [V-1:0] mb_vec;
         idx = -1;
         for (int i = 0; i < V; i++) begin
            if (idx < 0 && (!mbusy[i] || voice_done[i])) idx = i;
         end
         if (new_note !== '0) begin
            exp_g = '0;
            if (idx >= 0) exp_g[idx] = 1'b1;
            for (int i = 0; i < V; i++) mb_vec[i] = mbusy[i];
            chk("rnd_busy", voice_busy, mb_vec);
            chk("rnd_grant", new_note, exp_g);
            chk("rnd_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rnd_note", note, e.n);
               chk("rnd_dur", duration, e.d);
               chk("rnd_meta", meta, e.m);
            end
         end
         for (int i = 0; i < V; i++) begin
            if (voice_done[i]) mbusy[i] = 1'b0;
         end
         if (new_note !== '0 && idx >= 0) mbusy[idx] = 1'b1;
         if (song_done) done_seen = 1'b1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int pulses;
      int nn_seen;
      exp_t e;

      // ---------------- ROM contents ----------------
      for (int i = 0; i < (1 << (SB + AB)); i++) rom_mem[i] = ent(1'b1, 0, 0, 0);
      rom_mem[32] = ent(1'b1, 12, 4, 5);
      rom_mem[33] = ent(1'b0, 20, 0, 1);
      rom_mem[34] = ent(1'b0, 21, 0, 2);
      rom_mem[35] = ent(1'b1, 22, 0, 3);
      rom_mem[36] = ent(1'b1, 23, 2, 6);
      rom_mem[37] = ent(1'b1, 0, 2, 0);
      rom_mem[38] = ent(1'b1, 30, 3, 1);
      for (int i = 0; i < 4; i++) rom_mem[64 + i] = ent(1'b0, 40 + i, 0, i);

      // ---------------- reset state ----------------
      ticks(3);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_busy", voice_busy, 0);
      chk("rst_new_note", new_note, 0);
      chk("rst_song_done", song_done, 0);
      chk("rst_note", note, 0);
      chk("rst_dur", duration, 0);
      chk("rst_meta", meta, 0);
      reset = 1'b1;
      ticks(2);

      // ---------------- song 1: start latency ----------------
      song = 2'd1;
      play = 1'b1;                                  // cycle n
      tick();                                       // n+1 FETCH
      chk("start_fetch_addr", rom_addr, 7'h20);
      chk("start_no_note1", new_note, 0);
      tick();                                       // n+2 DECODE
      chk("start_no_note2", new_note, 0);
      tick();                                       // n+3 DISPATCH
      chk("first_new_note", new_note, 3'b001);
      chk("first_note", note, 12);
      chk("first_dur", duration, 4);
      chk("first_meta", meta, 5);
      beat = 1'b1;                                  // loads count: not counted
      tick();                                       // n+4 WAIT
      chk("first_busy", voice_busy, 3'b001);
      tick(); beat = 1'b1; voice_done = 3'b001;     // n+5 beat 1
      tick(); beat = 1'b1;                          // n+6 beat 2
      chk("done_clears_busy", voice_busy, 3'b000);
      tick(); beat = 1'b1;                          // n+7 beat 3
      tick();                                       // n+8
      tick(); beat = 1'b1;                          // n+9 beat 4
      chk("wait_hold_addr", rom_addr, 7'h20);
      tick();                                       // n+10 INCR
      chk("wait_incr_addr", rom_addr, 7'h20);
      tick();                                       // n+11 FETCH
      chk("after_4_beats_fetch", rom_addr, 7'h21);

      // ---------------- chord, then stall ----------------
      ticks(2);                                     // n+13
      chk("chord0_grant", new_note, 3'b001);
      chk("chord0_note", note, 20);
      ticks(4);                                     // n+17
      chk("chord1_grant", new_note, 3'b010);
      chk("chord1_note", note, 21);
      ticks(4);                                     // n+21
      chk("chord2_grant", new_note, 3'b100);
      chk("chord2_note", note, 22);
      ticks(4);                                     // n+25
      chk("stall_no_grant", new_note, 0);
      chk("stall_all_busy", voice_busy, 3'b111);
      ticks(3);                                     // n+28
      chk("stall_still", new_note, 0);
      voice_done = 3'b010;
      #1;
      chk("stall_release_grant", new_note, 3'b010);
      chk("stall_release_note", note, 23);
      tick(); beat = 1'b1;
      tick(); beat = 1'b1;
      wait_addr(7'h25, 6, "rest_fetch");            // f

      // ---------------- rest with 2 beats ----------------
      tick(); beat = 1'b1;                          // f+1 DECODE, not counted
      tick();                                       // f+2
      chk("rest_no_note", new_note, 0);
      tick(); beat = 1'b1; voice_done = 3'b101;     // f+3 beat 1
      tick();                                       // f+4
      tick();                                       // f+5
      chk("rest_one_beat_hold", rom_addr, 7'h25);
      chk("rest_busy", voice_busy, 3'b010);
      tick(); beat = 1'b1;                          // f+6 beat 2
      tick();                                       // f+7 INCR
      chk("rest_incr_hold", rom_addr, 7'h25);
      tick();                                       // f+8 FETCH
      chk("rest_next_fetch", rom_addr, 7'h26);

      // ---------------- freeze during WAIT ----------------
      ticks(2);                                     // f+10 DISPATCH
      chk("e6_grant", new_note, 3'b001);
      chk("e6_note", note, 30);
      tick();                                       // f+11 WAIT count 3
      play = 1'b0;
      song = 2'd3;                                  // must be ignored
      tick(); beat = 1'b1; voice_done = 3'b010;     // f+12
      tick(); beat = 1'b1;                          // f+13
      chk("freeze_done_clears", voice_busy, 3'b001);
      tick(); beat = 1'b1;                          // f+14
      tick();                                       // f+15
      chk("freeze_addr", rom_addr, 7'h26);
      play = 1'b1;
      tick(); beat = 1'b1;                          // f+16
      tick(); beat = 1'b1;                          // f+17
      tick();                                       // f+18
      chk("resume_two_beats_hold", rom_addr, 7'h26);
      beat = 1'b1;
      tick();                                       // f+19 INCR
      chk("resume_incr_hold", rom_addr, 7'h26);
      tick();                                       // f+20 FETCH
      chk("resume_fetch_song_kept", rom_addr, 7'h27);

      // ---------------- end of song ----------------
      k = 0;
      while (song_done !== 1'b1 && k < 300) begin
         tick();
         k++;
      end
      chk("song_done_pulse", song_done, 1'b1);
      tick();
      chk("song_done_one_cycle", song_done, 1'b0);
      chk("end_ptr_wrapped", rom_addr, 7'h20);
      pulses = 0;
      nn_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (song_done === 1'b1) pulses++;
         if (new_note !== '0) nn_seen++;
      end
      chk("no_extra_done", pulses, 0);
`ifdef SONG_SEQ_LOOP_EN
      chk("loop_redispatch", nn_seen, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      song  = 2'd2;
      tick();
`else
      chk("done_no_restart", nn_seen, 0);
      chk("done_holds_addr", rom_addr, 7'h20);
      play = 1'b0;
      tick();                                       // IDLE
      voice_done = 3'b111;
      song = 2'd2;
      play = 1'b1;
      tick();
`endif
      chk("song2_fetch", rom_addr, 7'h40);

      // ---------------- song 2: async reset while stalled ----------------
      ticks(2);
      chk("s2_grant0", new_note, 3'b001);
      chk("s2_note0", note, 40);
      ticks(4);
      chk("s2_grant1", new_note, 3'b010);
      ticks(4);
      chk("s2_grant2", new_note, 3'b100);
      chk("s2_meta2", meta, 2);
      ticks(4);
      chk("s2_stall", new_note, 0);
      chk("s2_all_busy", voice_busy, 3'b111);
      reset = 1'b0;
      #1;
      chk("arst_busy", voice_busy, 0);
      chk("arst_addr", rom_addr, 0);
      chk("arst_note", note, 0);
      chk("arst_dur", duration, 0);
      chk("arst_meta", meta, 0);
      chk("arst_new_note", new_note, 0);

      // ---------------- randomized song 3 ----------------
      for (int i = 0; i < 32; i++) begin
         int nv;
         int dv;
         int mv;
         logic av;
         nv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
         dv = int'($urandom_range(0, 5));
         mv = int'($urandom_range(0, 7));
         av = 1'($urandom_range(0, 1));
         rom_mem[96 + i] = ent(av, nv, dv, mv);
         if (nv != 0) begin
            e.n = NW'(nv);
            e.d = DW'(dv);
            e.m = MW'(mv);
            exp_q.push_back(e);
         end
      end
      for (int i = 0; i < V; i++) mbusy[i] = 1'b0;
      play = 1'b0;
      song = 2'd3;
      tick();
      reset = 1'b1;
      tick();
      mon_en = 1'b1;
      play   = 1'b1;
      k = 0;
      while (!done_seen && k < 20000) begin
         tick();
         k++;
         beat = ($urandom_range(0, 2) == 0);
         voice_done = V'($urandom_range(0, 7)) & {V{$urandom_range(0, 3) == 0}};
      end
      mon_en = 1'b0;
      chk("rnd_song_done", done_seen, 1'b1);
      chk("rnd_all_dispatched", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
